m_ex_muldiv: RTL



---
 rtl/m_muldiv_pkg.sv | 20 ++
 rtl/m_muldiv_divstep.sv | 22 ++
 rtl/m_ex_muldiv.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/m_muldiv_pkg.sv
// Shared op encoding, FSM states and iteration count for the EX-stage mul/div unit.
package m_muldiv_pkg;

    localparam int unsigned ITER_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } state_e;

endpackage

// File: rtl/m_muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference and emit a 1 quotient bit when it does not borrow.
module m_muldiv_divstep (
    input  logic [32:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {rem_in[31:0], dividend_bit};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        // rem_in[32] set means the shifted value already exceeds any 32-bit divisor
        q_bit   = rem_in[32] | ~diff[33];
        rem_out = q_bit ? diff[32:0] : shifted;
    end

endmodule

// File: rtl/m_ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, fixed 33-cycle latency.
// Divide support is built only when MULDIV_DIV_EN is defined.
module m_ex_muldiv
    import m_muldiv_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        mthiE,
    input  logic        mtloE,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CntW = $clog2(ITER);
    localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     acc_q, acc_d;
    logic [31:0]     opnd_q, opnd_d;
    logic            neg_res_q, neg_res_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;

    op_e         op;
    logic        signed_op, is_div, accept;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] prod;

    assign op        = op_e'(opE);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign mag_a     = (signed_op && srcaE[31]) ? -srcaE : srcaE;
    assign mag_b     = (signed_op && srcbE[31]) ? -srcbE : srcbE;

    // Shift-add: low half starts as the multiplier and drains out as product bits enter.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign prod    = neg_res_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic [32:0] rem_q, rem_d, step_rem;
    logic        step_q, div_q, div_d, neg_rem_q, neg_rem_d;

    m_muldiv_divstep u_divstep (
        .rem_in       (rem_q),
        .dividend_bit (acc_q[31]),
        .divisor      (opnd_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    assign accept = startE;
`else
    assign accept = startE && !is_div;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
        rem_d     = rem_q;
        div_d     = div_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = '0;
                    // Divide by zero keeps the quotient uncorrected so LO reads all ones.
                    neg_res_d = signed_op && (srcaE[31] ^ srcbE[31]) && (srcbE != 32'd0);
`ifdef MULDIV_DIV_EN
                    div_d     = is_div;
                    neg_rem_d = signed_op && srcaE[31];
                    rem_d     = '0;
`endif
                    if (is_div) begin
                        state_d = StDiv;
                        acc_d   = {32'd0, mag_a};
                        opnd_d  = mag_b;
                    end else begin
                        state_d = StMul;
                        acc_d   = {32'd0, mag_b};
                        opnd_d  = mag_a;
                    end
                end else if (!startE) begin
                    if (mthiE) hi_d = srcaE;
                    if (mtloE) lo_d = srcaE;
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) state_d = StFix;
            end
`ifdef MULDIV_DIV_EN
            StDiv: begin
                rem_d = step_rem;
                acc_d = {32'd0, acc_q[30:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) state_d = StFix;
            end
`endif
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    lo_d = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
                    hi_d = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
`else
                hi_d = prod[63:32];
                lo_d = prod[31:0];
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q     <= '0;
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MULDIV_DIV_EN
            rem_q     <= rem_d;
            div_q     <= div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule
